spi_flash_reader: RTL

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_pkg.sv | 20 ++
 rtl/spi_byte_shifter.sv | 33 +++
 rtl/spi_flash_reader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI flash reader: flash opcodes, bit-count limit and FSM state encoding.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam logic [3:0] BYTE_BITS = 4'd8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CS_SETUP = 3'd1;
  localparam state_t ST_CMD      = 3'd2;
  localparam state_t ST_ADDR     = 3'd3;
  localparam state_t ST_DUMMY    = 3'd4;
  localparam state_t ST_DATA     = 3'd5;
  localparam state_t ST_CS_HOLD  = 3'd6;
  localparam state_t ST_DONE     = 3'd7;

endpackage

// File: rtl/spi_byte_shifter.sv
// 8-bit shift register shared by every SPI phase: MSB is the outgoing bit, MISO enters at the LSB.
module spi_byte_shifter
  import spi_flash_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       sample,
  input  logic       miso,
  output logic [7:0] data,
  output logic [3:0] bit_cnt
);

  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
    end else if (sample) begin
      data <= {data[6:0], miso};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 4'd0;
    end else if (load) begin
      bit_cnt <= 4'd0;
    end else if (sample && bit_cnt != BYTE_BITS) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash read master: command, address, optional dummy byte, then len bytes streamed out.
// Define SPI_FLASH_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks instead of READ (0x03).
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int ADDR_BYTES = 3,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*ADDR_BYTES-1:0] addr,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    spi_cs_n,
  output logic                    spi_sck,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] READ_CMD  = CMD_FAST_READ;
  localparam logic       HAS_DUMMY = 1'b1;
`else
  localparam logic [7:0] READ_CMD  = CMD_READ;
  localparam logic       HAS_DUMMY = 1'b0;
`endif

  localparam logic [8:0] DIV_RELOAD  = 9'(CLK_DIV - 1);
  localparam logic [8:0] HOLD_RELOAD = 9'(2 * CLK_DIV - 1);
  localparam logic [2:0] ADDR_LAST   = 3'(ADDR_BYTES - 1);
  localparam int         AMSB        = 8 * ADDR_BYTES - 1;

  state_t                  state;
  logic [8:0]              div_cnt;
  logic [2:0]              byte_idx;
  logic [LEN_W-1:0]        len_cnt;
  logic [8*ADDR_BYTES-1:0] addr_q;

  logic       sh_load;
  logic [7:0] sh_load_data;
  logic [7:0] sh_data;
  logic [3:0] sh_bit_cnt;

  logic accept, div_done, shifting, tx_phase;
  logic rise, fall, byte_end, next_is_addr, data_finished, next_mosi;

  assign accept   = (state == ST_IDLE) && start;
  assign div_done = (div_cnt == 9'd0);
  assign shifting = (state == ST_CMD) || (state == ST_ADDR) ||
                    (state == ST_DUMMY) || (state == ST_DATA);
  assign tx_phase = (state == ST_CMD) || (state == ST_ADDR);

  // In DATA a new bit only starts once the previous byte is accepted and more bytes remain.
  assign rise = !spi_sck && div_done &&
                ((state == ST_CS_SETUP) || (state == ST_CMD) || (state == ST_ADDR) ||
                 (state == ST_DUMMY) ||
                 ((state == ST_DATA) && (len_cnt != '0) && !rd_valid));
  assign fall          = spi_sck && div_done && shifting;
  assign byte_end      = fall && (sh_bit_cnt == BYTE_BITS);
  assign next_is_addr  = byte_end &&
                         ((state == ST_CMD) || ((state == ST_ADDR) && (byte_idx != ADDR_LAST)));
  assign data_finished = (state == ST_DATA) && !spi_sck && div_done &&
                         (len_cnt == '0) && !rd_valid;

  always_comb begin
    next_mosi = 1'b0;
    if (byte_end) begin
      next_mosi = next_is_addr ? addr_q[AMSB] : 1'b0;
    end else if (tx_phase) begin
      next_mosi = sh_data[7];
    end
  end

  always_comb begin
    sh_load      = accept || byte_end;
    sh_load_data = 8'h00;
    if (accept) begin
      sh_load_data = READ_CMD;
    end else if (next_is_addr) begin
      sh_load_data = addr_q[AMSB -: 8];
    end
  end

  spi_byte_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (sh_load_data),
    .sample    (rise),
    .miso      (spi_miso),
    .data      (sh_data),
    .bit_cnt   (sh_bit_cnt)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= addr;
    end else if (next_is_addr) begin
      addr_q <= addr_q << 8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      div_cnt  <= 9'd0;
      byte_idx <= 3'd0;
      len_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (!div_done) begin
        div_cnt <= div_cnt - 9'd1;
      end
      if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end

      // Rising SCK: MISO is captured by the shifter on this same edge.
      if (rise) begin
        spi_sck <= 1'b1;
        div_cnt <= DIV_RELOAD;
        if (state == ST_CS_SETUP) begin
          state <= ST_CMD;
        end
        if ((state == ST_DATA) && (sh_bit_cnt == 4'd7)) begin
          rd_valid <= 1'b1;
          rd_data  <= {sh_data[6:0], spi_miso};
          if (len_cnt != '0) begin
            len_cnt <= len_cnt - LEN_W'(1);
          end
        end
      end

      if (fall) begin
        spi_sck  <= 1'b0;
        div_cnt  <= DIV_RELOAD;
        spi_mosi <= next_mosi;
        if (byte_end) begin
          case (state)
            ST_CMD:   state <= ST_ADDR;
            ST_ADDR: begin
              if (byte_idx == ADDR_LAST) begin
                state <= HAS_DUMMY ? ST_DUMMY : ST_DATA;
              end else begin
                byte_idx <= byte_idx + 3'd1;
              end
            end
            ST_DUMMY: state <= ST_DATA;
            default: ;
          endcase
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            len_cnt  <= len;
            byte_idx <= 3'd0;
            if (len == '0) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_CS_SETUP;
              spi_cs_n <= 1'b0;
              spi_mosi <= READ_CMD[7];
              div_cnt  <= DIV_RELOAD;
            end
          end
        end
        ST_DATA: begin
          if (data_finished) begin
            spi_cs_n <= 1'b1;
            div_cnt  <= HOLD_RELOAD;
            state    <= ST_CS_HOLD;
          end
        end
        ST_CS_HOLD: begin
          if (div_done) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
